alu_uart_ctrl: RTL and testbench
================================

# alu_uart_ctrl

Byte-stream sequencer for the ALU execute stage. It collects operand A, operand B and an opcode from a serial receiver's byte interface and holds them stable on the ALU inputs. It then captures the ALU result and carry, and returns them as two bytes through a transmitter start/done handshake. It sits between the UART RX/TX blocks and the ALU, replacing switch/button operand loading.

## Interface
- NB_DATA, 8, operand, result and serial byte width
- NB_OP, 6, opcode width (low NB_OP bits of the opcode byte)
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes of one transaction; must be >= 2
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_DATA  received byte, valid only while i_rx_valid=1
- i_rx_valid  in  1  one-cycle strobe per received byte
- o_alu_a  out  NB_DATA  registered operand A to ALU
- o_alu_b  out  NB_DATA  registered operand B to ALU
- o_alu_op  out  NB_OP  registered opcode to ALU
- i_alu_res  in  NB_DATA  combinational ALU result
- i_alu_carry  in  1  combinational ALU carry
- o_tx_data  out  NB_DATA  byte to transmitter, held stable from o_tx_start until i_tx_done
- o_tx_start  out  1  one-cycle request to send o_tx_data
- i_tx_done  in  1  one-cycle strobe, transmitter finished current byte
- o_busy  out  1  high in every state except WAIT_A
- o_err  out  1  one-cycle pulse: invalid opcode or inter-byte timeout

## Operation
- Valid opcodes (low NB_OP bits): ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02. Upper byte bits are ignored.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_ST, WAIT_ST.
- WAIT_A: on i_rx_valid, load o_alu_a and go to WAIT_B.
- WAIT_B: on i_rx_valid, load o_alu_b and go to WAIT_OP.
- WAIT_OP, valid opcode: load o_alu_op and go to EXEC.
- WAIT_OP, invalid opcode: o_alu_op is unchanged, o_err pulses, go to WAIT_A. A and B keep the new values.
- EXEC: register {i_alu_res, i_alu_carry} into internal capture registers, then go to SEND_RES.
- SEND_RES: o_tx_data = captured result, o_tx_start = 1 for one cycle, go to WAIT_RES.
- WAIT_RES: hold o_tx_data. On i_tx_done, go to SEND_ST.
- SEND_ST: o_tx_data = status byte, with bit0 = captured carry and all other bits 0. o_tx_start = 1 for one cycle, go to WAIT_ST.
- WAIT_ST: on i_tx_done, go to WAIT_A.
- Inter-byte timeout:
  - A counter clears on entry to WAIT_B/WAIT_OP and on every accepted byte, and increments each cycle in those states without i_rx_valid.
  - When the count reaches TIMEOUT_CYCLES-1 with no i_rx_valid, go to WAIT_A and pulse o_err.
  - If i_rx_valid arrives on the expiry cycle, the byte is accepted and there is no error.
- i_rx_valid in EXEC through WAIT_ST is dropped, with no effect and no error.
- i_tx_done outside WAIT_RES/WAIT_ST is ignored.
- o_alu_a/b/op hold their last values between transactions and are never cleared except by reset.
- No arithmetic in this block; widths pass through unchanged.

## Timing
- Reset values: state WAIT_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data, capture registers and timeout counter all 0; o_tx_start=0, o_err=0, o_busy=0.
- Reset anywhere, including mid-send, returns to WAIT_A on the next edge. Any pending transmission is abandoned, with no further o_tx_start.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- The opcode byte is accepted on edge N:
  - N+1: state EXEC, o_alu_op valid.
  - N+2: state SEND_RES, capture done, o_tx_start=1.
  - N+3: o_tx_start=0.
- First i_tx_done on edge M gives o_tx_start for the status byte high during cycle M+1.
- Second i_tx_done on edge K gives state WAIT_A and o_busy=0 at K+1; a new byte A is accepted from K+1.
- o_err is high for exactly the one cycle after the cause edge.

## Test plan
- Bytes 0x05, 0x03, 0x20 with tx_done returned 5 cycles after each start: tx 0x08 then 0x00, two o_tx_start pulses, o_busy falls after the second tx_done.
- Bytes 0xFF, 0x01, 0x20: tx 0x00 then 0x01 (carry set). Then 0x80, 0x01, 0x03: tx 0xC0 then the status byte.
- Bytes 0x10, 0x20, 0x3F: o_err pulses once, no o_tx_start, o_alu_op keeps its previous value, next transaction works normally.
- With TIMEOUT_CYCLES=16, send 0x07 then nothing: o_err pulses 16 cycles after the A byte and state is WAIT_A. Repeat with B arriving exactly on cycle 15: accepted, no error.
- Extra bytes injected during WAIT_RES, and a spurious i_tx_done in WAIT_A: no change to tx data or state.
- Assert i_reset during WAIT_RES: all outputs return to reset values next cycle, and the following transaction 0x02, 0x02, 0x22 yields 0x00.

Source files
------------

// File: rtl/alu_uart_ctrl.sv
// Byte-stream sequencer between UART RX/TX and the ALU: collects A, B and an
// opcode, holds them on the ALU inputs, then returns the result and carry bytes.
module alu_uart_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_res,
  input  logic               i_alu_carry,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_B   = 3'd1,
    WAIT_OP  = 3'd2,
    EXEC     = 3'd3,
    SEND_RES = 3'd4,
    WAIT_RES = 3'd5,
    SEND_ST  = 3'd6,
    WAIT_ST  = 3'd7
  } state_t;

  state_t             state_r, state_s;
  logic [NB_DATA-1:0] alu_a_r, alu_a_s;
  logic [NB_DATA-1:0] alu_b_r, alu_b_s;
  logic [NB_OP-1:0]   alu_op_r, alu_op_s;
  logic [NB_DATA-1:0] tx_data_r, tx_data_s;
  logic [NB_DATA-1:0] res_cap_r, res_cap_s;
  logic               carry_cap_r, carry_cap_s;
  logic               tx_start_r, tx_start_s;
  logic               err_r, err_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               tmo_hit_s;
  logic [NB_OP-1:0]   rx_op_s;

  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    logic ok;
    case (op)
      NB_OP'(6'h20), NB_OP'(6'h22), NB_OP'(6'h24), NB_OP'(6'h25),
      NB_OP'(6'h26), NB_OP'(6'h27), NB_OP'(6'h03), NB_OP'(6'h02): ok = 1'b1;
      default:                                                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign tmo_hit_s = (cnt_r == TMO_LAST);
  assign rx_op_s   = i_rx_data[NB_OP-1:0];

  // State register and all output/capture registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r     <= WAIT_A;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_op_r    <= '0;
      tx_data_r   <= '0;
      res_cap_r   <= '0;
      carry_cap_r <= 1'b0;
      tx_start_r  <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_s;
      alu_a_r     <= alu_a_s;
      alu_b_r     <= alu_b_s;
      alu_op_r    <= alu_op_s;
      tx_data_r   <= tx_data_s;
      res_cap_r   <= res_cap_s;
      carry_cap_r <= carry_cap_s;
      tx_start_r  <= tx_start_s;
      err_r       <= err_s;
      cnt_r       <= cnt_s;
    end
  end

  // Next-state and next-register decode; the timeout counter is zero unless
  // it is counting idle cycles in WAIT_B/WAIT_OP.
  always_comb begin
    state_s     = state_r;
    alu_a_s     = alu_a_r;
    alu_b_s     = alu_b_r;
    alu_op_s    = alu_op_r;
    tx_data_s   = tx_data_r;
    res_cap_s   = res_cap_r;
    carry_cap_s = carry_cap_r;
    tx_start_s  = 1'b0;
    err_s       = 1'b0;
    cnt_s       = '0;
    case (state_r)
      WAIT_A: begin
        if (i_rx_valid) begin
          alu_a_s = i_rx_data;
          state_s = WAIT_B;
        end else begin
          state_s = WAIT_A;
        end
      end
      WAIT_B: begin
        if (i_rx_valid) begin
          alu_b_s = i_rx_data;
          state_s = WAIT_OP;
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = WAIT_A;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1'b1);
          state_s = WAIT_B;
        end
      end
      WAIT_OP: begin
        if (i_rx_valid) begin
          if (op_valid(rx_op_s)) begin
            alu_op_s = rx_op_s;
            state_s  = EXEC;
          end else begin
            err_s    = 1'b1;
            state_s  = WAIT_A;
          end
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          state_s = WAIT_A;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1'b1);
          state_s = WAIT_OP;
        end
      end
      EXEC: begin
        // The result byte is loaded straight into tx_data so it is valid in
        // the same cycle as the start strobe.
        res_cap_s   = i_alu_res;
        carry_cap_s = i_alu_carry;
        tx_data_s   = i_alu_res;
        tx_start_s  = 1'b1;
        state_s     = SEND_RES;
      end
      SEND_RES: begin
        state_s = WAIT_RES;
      end
      WAIT_RES: begin
        if (i_tx_done) begin
          tx_data_s  = {{(NB_DATA-1){1'b0}}, carry_cap_r};
          tx_start_s = 1'b1;
          state_s    = SEND_ST;
        end else begin
          state_s    = WAIT_RES;
        end
      end
      SEND_ST: begin
        state_s = WAIT_ST;
      end
      WAIT_ST: begin
        if (i_tx_done) begin
          state_s = WAIT_A;
        end else begin
          state_s = WAIT_ST;
        end
      end
      default: begin
        state_s = WAIT_A;
      end
    endcase
  end

  assign o_alu_a    = alu_a_r;
  assign o_alu_b    = alu_b_r;
  assign o_alu_op   = alu_op_r;
  assign o_tx_data  = tx_data_r;
  assign o_tx_start = tx_start_r;
  assign o_err      = err_r;
  assign o_busy     = (state_r != WAIT_A);

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_alu_uart_ctrl;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] alu_a, alu_b, alu_res, tx_data;
  logic [5:0] alu_op;
  logic       alu_carry, tx_start, tx_done, busy, err;
  logic       resp_done, spur_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign tx_done = resp_done | spur_done;

  alu_uart_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_res(alu_res), .i_alu_carry(alu_carry),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_err(err));

  logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  function automatic bit is_op(input logic [5:0] op);
    for (int i = 0; i < 8; i++) if (valid_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // {carry, result}; SUB carry is the borrow
  function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return {1'b0, a} + {1'b0, b};
      6'h22:   return {(a < b), 8'(a - b)};
      6'h24:   return {1'b0, a & b};
      6'h25:   return {1'b0, a | b};
      6'h26:   return {1'b0, a ^ b};
      6'h27:   return {1'b0, ~(a | b)};
      6'h03:   return {1'b0, 8'($signed(a) >>> b)};
      6'h02:   return {1'b0, a >> b};
      default: return 9'h000;
    endcase
  endfunction

  always_comb {alu_carry, alu_res} = ref_alu(alu_a, alu_b, alu_op);

  // Monitor: samples 1 time unit after each rising edge
  int         cyc = 0, starts = 0, errs = 0, hold_err = 0, fall_cyc = 0;
  logic       pend = 1'b0, prev_busy = 1'b0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] tx_q [$];
  int         start_cyc_q [$];
  int         done_cyc_q [$];

  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (i_reset || tx_done) pend = 1'b0;
      else if (pend && tx_data !== last_tx) hold_err++;
      if (tx_done) done_cyc_q.push_back(cyc);
      if (tx_start) begin
        pend = 1'b1; last_tx = tx_data;
        tx_q.push_back(tx_data); start_cyc_q.push_back(cyc); starts++;
      end
      if (err) errs++;
      if (prev_busy && !busy) fall_cyc = cyc;
      prev_busy = busy;
    end
  end

  // Transmitter model: done strobe resp_dly cycles after each start
  int resp_dly = 5;
  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (tx_start) begin
        repeat (resp_dly - 1) @(negedge clk);
        resp_done = 1'b1;
      end
    end
  end

  logic [5:0] exp_op = 6'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #2; rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin tick(1); n++; end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ob);
    logic [5:0] op;
    logic [8:0] r;
    int s0, e0;
    op = ob[5:0]; r = ref_alu(a, b, op); s0 = starts; e0 = errs;
    tx_q.delete();
    put(a); put(b); put(ob);
    wait_idle("txn_idle");
    if (is_op(op)) begin
      exp_op = op;
      chk("txn_nbytes", tx_q.size(), 2);
      chk("txn_res", tx_q[0], r[7:0]);
      chk("txn_status", tx_q[1], {7'd0, r[8]});
      chk("txn_noerr", errs - e0, 0);
    end else begin
      chk("bad_nostart", starts - s0, 0);
      chk("bad_err", errs - e0, 1);
    end
    chk("txn_a", alu_a, a);
    chk("txn_b", alu_b, b);
    chk("txn_op", alu_op, exp_op);
  endtask

  initial begin
    logic [7:0] a, b, ob;
    int s0, e0;
    i_reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; spur_done = 1'b0;
    tick(2);
    chk("rst_a", alu_a, 0); chk("rst_b", alu_b, 0); chk("rst_op", alu_op, 0);
    chk("rst_tx", tx_data, 0); chk("rst_start", tx_start, 0);
    chk("rst_err", err, 0); chk("rst_busy", busy, 0);
    @(negedge clk); i_reset = 1'b0;

    // First transaction with cycle-level timing
    tx_q.delete(); start_cyc_q.delete(); done_cyc_q.delete(); s0 = starts;
    put(8'h05); put(8'h03); put(8'h20);
    chk("t1_op", alu_op, 8'h20); chk("t1_a", alu_a, 8'h05); chk("t1_b", alu_b, 8'h03);
    chk("t1_nostart", tx_start, 0); chk("t1_busy", busy, 1);
    tick(1);
    chk("t1_start", tx_start, 1); chk("t1_data", tx_data, 8'h08);
    tick(1);
    chk("t1_start_off", tx_start, 0);
    wait_idle("t1_idle");
    chk("t1_nbytes", tx_q.size(), 2); chk("t1_res", tx_q[0], 8'h08); chk("t1_st", tx_q[1], 8'h00);
    chk("t1_starts", starts - s0, 2);
    chk("t1_st_timing", start_cyc_q[1], done_cyc_q[0]);
    chk("t1_busy_fall", fall_cyc, done_cyc_q[1]);
    exp_op = 6'h20;

    run_txn(8'hFF, 8'h01, 8'h20);
    chk("add_carry_res", tx_q[0], 8'h00); chk("add_carry_st", tx_q[1], 8'h01);
    run_txn(8'h80, 8'h01, 8'h03);
    chk("sra_res", tx_q[0], 8'hC0);

    // Invalid opcode
    e0 = errs;
    put(8'h10); put(8'h20); put(8'h3F);
    chk("bad_err_pulse", err, 1); chk("bad_idle", busy, 0);
    tick(1);
    chk("bad_err_once", err, 0);
    chk("bad_op_kept", alu_op, 8'h03); chk("bad_a", alu_a, 8'h10); chk("bad_b", alu_b, 8'h20);
    chk("bad_errcnt", errs - e0, 1);
    run_txn(8'h0F, 8'h3C, 8'h24);

    // Timeout waiting for B, then waiting for the opcode
    e0 = errs;
    put(8'h07); tick(TMO - 1);
    chk("tmo_b_early", err, 0); chk("tmo_b_busy", busy, 1);
    tick(1);
    chk("tmo_b_err", err, 1); chk("tmo_b_idle", busy, 0);
    tick(1);
    chk("tmo_b_once", err, 0);
    put(8'h12); put(8'h34); tick(TMO - 1);
    chk("tmo_op_early", err, 0);
    tick(1);
    chk("tmo_op_err", err, 1); chk("tmo_op_idle", busy, 0);
    chk("tmo_errcnt", errs - e0, 2);

    // B lands exactly on the expiry cycle
    e0 = errs; tx_q.delete();
    put(8'h07); tick(TMO - 1); put(8'h09);
    chk("tmo_edge_noerr", err, 0); chk("tmo_edge_busy", busy, 1); chk("tmo_edge_b", alu_b, 8'h09);
    put(8'h22); wait_idle("tmo_edge_idle");
    exp_op = 6'h22;
    chk("tmo_edge_res", tx_q[0], 8'hFE); chk("tmo_edge_st", tx_q[1], 8'h01);
    chk("tmo_edge_errcnt", errs - e0, 0);

    // Stray bytes during WAIT_RES, then a spurious tx_done while idle
    resp_dly = 12; tx_q.delete();
    put(8'h33); put(8'h11); put(8'h26); tick(1);
    put(8'hAA); put(8'h55); put(8'h20);
    chk("stray_tx", tx_data, 8'h22); chk("stray_a", alu_a, 8'h33);
    chk("stray_b", alu_b, 8'h11); chk("stray_op", alu_op, 8'h26); chk("stray_busy", busy, 1);
    wait_idle("stray_idle");
    exp_op = 6'h26;
    chk("stray_nbytes", tx_q.size(), 2); chk("stray_res", tx_q[0], 8'h22); chk("stray_st", tx_q[1], 8'h00);
    s0 = starts; e0 = errs;
    @(negedge clk); spur_done = 1'b1;
    @(posedge clk); #2; spur_done = 1'b0;
    tick(2);
    chk("spur_busy", busy, 0); chk("spur_starts", starts - s0, 0);
    chk("spur_tx", tx_data, 8'h00); chk("spur_err", errs - e0, 0);

    // Reset while waiting for the result byte to finish
    resp_dly = 10;
    put(8'h09); put(8'h04); put(8'h20); tick(3);
    chk("rst2_busy_pre", busy, 1);
    s0 = starts;
    @(negedge clk); i_reset = 1'b1;
    @(posedge clk); #2;
    chk("rst2_a", alu_a, 0); chk("rst2_b", alu_b, 0); chk("rst2_op", alu_op, 0);
    chk("rst2_tx", tx_data, 0); chk("rst2_start", tx_start, 0);
    chk("rst2_err", err, 0); chk("rst2_busy", busy, 0);
    @(negedge clk); i_reset = 1'b0;
    exp_op = 6'h00;
    tick(15);
    chk("rst2_nostart", starts - s0, 0); chk("rst2_idle", busy, 0);
    resp_dly = 5;
    run_txn(8'h02, 8'h02, 8'h22);
    chk("rst2_res", tx_q[0], 8'h00);

    // Random transactions
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); b = 8'($urandom_range(0, 255));
      resp_dly = $urandom_range(2, 8);
      if ($urandom_range(0, 4) == 0) ob = 8'($urandom);
      else ob = {2'($urandom), valid_ops[$urandom_range(0, 7)]};
      run_txn(a, b, ob);
    end

    chk("tx_hold_stable", hold_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
